// File: rtl/pkg_arbiter_rr_pkg.sv
// Shared types and helpers for the round-robin packet arbiter.
package pkg_arbiter_rr_pkg;

  // Arbiter state: no grant, or a grant locked for the duration of a packet.
  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  // Beats a packet may last before the watchdog forces a release.
  localparam int DEFAULT_MAX_BEATS = 64;

  // Index after idx, wrapping back to zero at n.
  function automatic int wrap_inc(input int idx, input int n);
    int nxt;
    nxt = idx + 1;
    if (nxt >= n) begin
      nxt = 0;
    end else begin
      nxt = idx + 1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pkg_arbiter_rr_if.sv
// Request/grant bundle between the packet sources and the arbiter.
interface pkg_arbiter_rr_if #(
  parameter int N   = 5,
  parameter int IDW = $clog2(N)
);
  logic [N-1:0]   req;
  logic [N-1:0]   eop;
  logic           beat;
  logic           clear;
  logic [N-1:0]   gnt;
  logic           any_gnt;
  logic [IDW-1:0] gnt_id;
  logic           timeout;

  // Side that drives requests and beats and observes the grant.
  modport master (
    output req, eop, beat, clear,
    input  gnt, any_gnt, gnt_id, timeout
  );

  // Arbiter side.
  modport slave (
    input  req, eop, beat, clear,
    output gnt, any_gnt, gnt_id, timeout
  );
endinterface

// File: rtl/pkg_arbiter_rr_rr_pick.sv
// Combinational round-robin pick: the first unexcluded request at or after ptr.
module rr_pick #(
  parameter int N   = 5,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic [N-1:0]   excl,
  output logic [N-1:0]   pick,
  output logic [IDW-1:0] idx,
  output logic           found
);

  logic [N-1:0]   masked_s;
  logic [2*N-1:0] dbl_s;
  logic [N-1:0]   rot_s;
  int             off_s;
  int             sum_s;

  // Rotate the masked requests so that ptr lands on bit 0, then priority-encode.
  always_comb begin
    masked_s = req & ~excl;
    dbl_s    = {masked_s, masked_s};
    for (int i = 0; i < N; i++) begin
      rot_s[i] = dbl_s[i + int'(ptr)];
    end
    // Scan from the top down so that the lowest set offset is the one kept.
    off_s = 0;
    for (int i = N - 1; i >= 0; i--) begin
      off_s = rot_s[i] ? i : off_s;
    end
    sum_s = int'(ptr) + off_s;
    if (sum_s >= N) begin
      sum_s = sum_s - N;
    end else begin
      sum_s = int'(ptr) + off_s;
    end
    found = |rot_s;
    idx   = IDW'(sum_s);
    pick  = found ? ({{(N-1){1'b0}}, 1'b1} << sum_s) : {N{1'b0}};
  end

endmodule

// File: rtl/pkg_arbiter_rr.sv
// Round-robin packet arbiter: the grant is held for a whole multi-beat packet,
// handed over back-to-back on release, and force-released by a beat watchdog.
module pkg_arbiter_rr
  import pkg_arbiter_rr_pkg::*;
#(
  parameter int N         = 5,
  parameter int MAX_BEATS = DEFAULT_MAX_BEATS,
  parameter int IDW       = $clog2(N),
  parameter int CW        = $clog2(MAX_BEATS + 1)
) (
  input logic             clk,
  input logic             rst,
  pkg_arbiter_rr_if.slave bus
);

  // With the watchdog disabled CW collapses to 0; keep at least one bit.
  localparam int CNT_W = (CW < 1) ? 1 : CW;

  arb_state_e     state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic           any_gnt_q, any_gnt_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic           timeout_q, timeout_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic           own_req_s;
  logic           own_eop_s;
  logic           fin_s;
  logic           wdog_s;
  logic           release_s;
  logic [IDW-1:0] next_ptr_s;
  logic [IDW-1:0] pick_ptr_s;
  logic [N-1:0]   excl_s;
  logic [N-1:0]   pick_s;
  logic [IDW-1:0] pick_idx_s;
  logic           pick_found_s;

  // Release conditions of the current owner and the operands for the next pick.
  always_comb begin
    // gnt_q is one-hot in LOCK, so masking selects the owner's own bits.
    own_req_s = |(bus.req & gnt_q);
    own_eop_s = |(bus.eop & gnt_q);
    if (state_q == ARB_LOCK) begin
      fin_s = bus.beat & own_eop_s;
      if (MAX_BEATS != 0) begin
        // Only without eop: a packet ending on its last allowed beat is normal.
        wdog_s = bus.beat & ~own_eop_s & (int'(cnt_q) == MAX_BEATS - 1);
      end else begin
        wdog_s = 1'b0;
      end
      release_s = fin_s | wdog_s | ~own_req_s;
      excl_s    = gnt_q;
    end else begin
      fin_s     = 1'b0;
      wdog_s    = 1'b0;
      release_s = 1'b0;
      excl_s    = {N{1'b0}};
    end
    next_ptr_s = IDW'(wrap_inc(int'(gnt_id_q), N));
    // On release the new pick already starts after the releasing requester.
    pick_ptr_s = release_s ? next_ptr_s : ptr_q;
  end

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req   (bus.req),
    .ptr   (pick_ptr_s),
    .excl  (excl_s),
    .pick  (pick_s),
    .idx   (pick_idx_s),
    .found (pick_found_s)
  );

  // Next-state logic; clear overrides everything else.
  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = ARB_IDLE;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_found_s) begin
            state_d = ARB_LOCK;
          end else begin
            state_d = ARB_IDLE;
          end
        end
        ARB_LOCK: begin
          if (release_s && !pick_found_s) begin
            state_d = ARB_IDLE;
          end else begin
            state_d = ARB_LOCK;
          end
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

  // Grant, pointer, beat counter and timeout for the next cycle.
  always_comb begin
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    if (bus.clear) begin
      // Abort wins over a coinciding release, so ptr is left alone.
      gnt_d = {N{1'b0}};
      cnt_d = {CNT_W{1'b0}};
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_found_s) begin
            gnt_d    = pick_s;
            gnt_id_d = pick_idx_s;
            cnt_d    = {CNT_W{1'b0}};
          end else begin
            gnt_d = {N{1'b0}};
          end
        end
        ARB_LOCK: begin
          if (release_s) begin
            ptr_d     = next_ptr_s;
            cnt_d     = {CNT_W{1'b0}};
            timeout_d = wdog_s;
            if (pick_found_s) begin
              gnt_d    = pick_s;
              gnt_id_d = pick_idx_s;
            end else begin
              gnt_d = {N{1'b0}};
            end
          end else if (bus.beat && (int'(cnt_q) < MAX_BEATS)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            cnt_d = cnt_q;
          end
        end
        default: begin
          gnt_d = {N{1'b0}};
          cnt_d = {CNT_W{1'b0}};
        end
      endcase
    end
    any_gnt_d = |gnt_d;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Output, pointer and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_q     <= {N{1'b0}};
      any_gnt_q <= 1'b0;
      gnt_id_q  <= {IDW{1'b0}};
      timeout_q <= 1'b0;
      ptr_q     <= {IDW{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
    end else begin
      gnt_q     <= gnt_d;
      any_gnt_q <= any_gnt_d;
      gnt_id_q  <= gnt_id_d;
      timeout_q <= timeout_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.any_gnt = any_gnt_q;
  assign bus.gnt_id  = gnt_id_q;
  assign bus.timeout = timeout_q;

endmodule
